// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with a two-flop synchronizer, mid-bit sampling,
//            start-glitch rejection, framing-error detection and a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset_n,
    input  logic                             i_Rx_Serial,
    output logic                             o_Rx_DV,
    output logic [7:0]                       o_Rx_Byte,
    input  logic                             i_Rx_Ready,
    output logic                             o_Rx_Active,
    output logic                             o_Frame_Err,
    output logic                             o_Overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_Fifo_Count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [15:0] c_HALF = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] c_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_DATA    = 3'd2;
    localparam logic [2:0] c_STOP    = 3'd3;
    localparam logic [2:0] c_CLEANUP = 3'd4;

    logic        sync1_q, rx_s_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        w_stop_ok, w_stop_bad;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          fe_q, ov_q;
    logic          w_full, w_pop, w_push, w_ovr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
        case (state_q)
            c_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = c_START;
            end
            c_START: begin
                if (cnt_q == c_HALF) begin
                    cnt_d   = '0;
                    // A line that is high again at mid-start was only a glitch.
                    state_d = rx_s_q ? c_IDLE : c_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            c_DATA: begin
                if (cnt_q == c_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = c_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            c_STOP: begin
                if (cnt_q == c_LAST) begin
                    cnt_d      = '0;
                    w_stop_ok  = rx_s_q;
                    w_stop_bad = !rx_s_q;
                    state_d    = c_CLEANUP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            c_CLEANUP: begin
                // Hold here through a break so a stuck-low line cannot retrigger.
                if (rx_s_q) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    assign w_full = (count_q == CW'(FIFO_DEPTH));
    assign w_pop  = o_Rx_DV && i_Rx_Ready;
    assign w_push = w_stop_ok && (!w_full || w_pop);
    assign w_ovr  = w_stop_ok && w_full && !w_pop;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= c_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q <= i_Rx_Serial;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            fe_q    <= w_stop_bad;
            ov_q    <= w_ovr;
            if (w_push) begin
                mem_q[wr_q] <= shift_q;
                wr_q        <= wr_q + PW'(1);
            end
            if (w_pop) rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_Rx_DV      = (count_q != '0);
    assign o_Rx_Byte    = mem_q[rd_q];
    assign o_Rx_Active  = (state_q != c_IDLE);
    assign o_Frame_Err  = fe_q;
    assign o_Overrun    = ov_q;
    assign o_Fifo_Count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed bench for uart_rx with CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic       dv;
    logic [7:0] rbyte;
    logic       active;
    logic       fe;
    logic       ov;
    logic [2:0] cnt;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] pop_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_pops;
        int         exp_fe;
    } vec_t;
    vec_t tbl[7];

    uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Rx_Serial  (rx),
        .o_Rx_DV      (dv),
        .o_Rx_Byte    (rbyte),
        .i_Rx_Ready   (ready),
        .o_Rx_Active  (active),
        .o_Frame_Err  (fe),
        .o_Overrun    (ov),
        .o_Fifo_Count (cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fe) fe_cnt++;
        if (ov) ov_cnt++;
        if (dv && ready) pop_q.push_back(rbyte);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(C);
    endtask

    task automatic send_data(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_data(d);
        drive_bit(stop);
    endtask

    task automatic drain();
        ready = 1'b1;
        idle(6);
        ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " dv"},     32'(dv),     32'd0);
        check({tag, " byte"},   32'(rbyte),  32'd0);
        check({tag, " active"}, 32'(active), 32'd0);
        check({tag, " fe"},     32'(fe),     32'd0);
        check({tag, " ov"},     32'(ov),     32'd0);
        check({tag, " count"},  32'(cnt),    32'd0);
    endtask

    initial begin
        int fe0, ov0;
        logic [7:0] exp6 [5];

        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        idle(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        idle(4);

        // Start glitch: two low cycles must be rejected at the mid-start check.
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(2);
        check("glitch active high", 32'(active), 32'd1);
        idle(5);
        check("glitch active fell", 32'(active), 32'd0);
        check("glitch count", 32'(cnt), 32'd0);
        check("glitch fe", 32'(fe_cnt), 32'd0);

        // Exact push latency: DV rises one cycle after the stop sample.
        send_data(8'hA5);
        rx = 1'b1;
        idle(6);
        check("latency dv before", 32'(dv), 32'd0);
        idle(1);
        check("latency dv after", 32'(dv), 32'd1);
        check("latency byte", 32'(rbyte), 32'hA5);
        check("latency count", 32'(cnt), 32'd1);
        idle(1);
        pop_q.delete();
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        check("latency popped dv", 32'(dv), 32'd0);
        check("latency pop size", 32'(pop_q.size()), 32'd1);
        if (pop_q.size() > 0) check("latency pop byte", 32'(pop_q[0]), 32'hA5);

        tbl[0] = '{8'hA5, 1'b1, 1, 0};
        tbl[1] = '{8'h5A, 1'b1, 1, 0};
        tbl[2] = '{8'h00, 1'b1, 1, 0};
        tbl[3] = '{8'hFF, 1'b1, 1, 0};
        tbl[4] = '{8'h81, 1'b0, 0, 1};
        tbl[5] = '{8'hC3, 1'b1, 1, 0};
        tbl[6] = '{8'h3C, 1'b0, 0, 1};
        ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            pop_q.delete();
            send_frame(tbl[v].data, tbl[v].stop);
            rx = 1'b1;
            idle(C);
            check($sformatf("vec%0d pops", v), 32'(pop_q.size()), 32'(tbl[v].exp_pops));
            if (pop_q.size() > 0)
                check($sformatf("vec%0d byte", v), 32'(pop_q[0]), 32'(tbl[v].data));
            check($sformatf("vec%0d fe", v), 32'(fe_cnt - fe0), 32'(tbl[v].exp_fe));
            check($sformatf("vec%0d ov", v), 32'(ov_cnt - ov0), 32'd0);
            check($sformatf("vec%0d dv", v), 32'(dv), 32'd0);
        end
        ready = 1'b0;

        // Back-to-back frames under backpressure.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(2);
        check("b2b count", 32'(cnt), 32'd3);
        pop_q.delete();
        drain();
        check("b2b pops", 32'(pop_q.size()), 32'd3);
        if (pop_q.size() == 3) begin
            check("b2b pop0", 32'(pop_q[0]), 32'h00);
            check("b2b pop1", 32'(pop_q[1]), 32'hFF);
            check("b2b pop2", 32'(pop_q[2]), 32'h3C);
        end
        check("b2b flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        // Framing error followed by a long break.
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b0);
        rx = 1'b0;
        idle(40);
        check("break fe pulses", 32'(fe_cnt - fe0), 32'd1);
        check("break active", 32'(active), 32'd1);
        check("break count", 32'(cnt), 32'd0);
        rx = 1'b1;
        idle(4);
        check("break released", 32'(active), 32'd0);
        check("break no frame", 32'(cnt), 32'd0);
        check("break fe single", 32'(fe_cnt - fe0), 32'd1);

        // Overrun on the fifth byte, then a push coinciding with a pop.
        ov0 = ov_cnt;
        pop_q.delete();
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        idle(2);
        check("ovr count", 32'(cnt), 32'd4);
        check("ovr pulses", 32'(ov_cnt - ov0), 32'd1);
        ov0 = ov_cnt;
        send_data(8'h06);
        rx = 1'b1;
        idle(6);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        idle(3);
        check("simul count", 32'(cnt), 32'd4);
        check("simul no ovr", 32'(ov_cnt - ov0), 32'd0);
        drain();
        exp6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        check("simul pops", 32'(pop_q.size()), 32'd5);
        if (pop_q.size() == 5)
            for (int k = 0; k < 5; k++)
                check($sformatf("simul pop%0d", k), 32'(pop_q[k]), 32'(exp6[k]));

        // Reset in the middle of a data bit with a byte already stored.
        send_frame(8'h77, 1'b1);
        idle(2);
        check("midrst pre count", 32'(cnt), 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        idle(3);
        rst_n = 1'b0;
        idle(3);
        check_idle_outputs("midrst");
        rst_n = 1'b1;
        rx    = 1'b1;
        idle(10);
        pop_q.delete();
        ready = 1'b1;
        send_frame(8'h96, 1'b1);
        idle(4);
        ready = 1'b0;
        check("midrst pops", 32'(pop_q.size()), 32'd1);
        if (pop_q.size() > 0) check("midrst byte", 32'(pop_q[0]), 32'h96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
